// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the single data-memory port between the M-stage
// CPU access and a DMA/loader requester. Each access runs IDLE -> BUSY
// (MEM_LAT cycles) -> RESP. Byte enables and lane-replicated store data are
// derived from the latched address and size.
// Optional macro ALIGN_CHECK_EN: misaligned CPU word/half accesses are
// rejected in IDLE with a cpu_adel_ades pulse instead of reaching DM.
module dm_access_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cpu_adel_ades
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);
    localparam logic [2:0] STARVE_TOP = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        owner_dma_q, owner_dma_d;
    logic        req_we_q, req_we_d;
    logic [1:0]  req_size_q, req_size_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [1:0]  lat_q, lat_d;
    logic [2:0]  starve_q, starve_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_done_q, cpu_done_d;
    logic        dma_done_q, dma_done_d;
    logic        misalign;
    logic        cpu_ok;

    // Byte enables from access size and low address bits (size 11 acts as word)
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b0001 << a;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across all lanes it may land in
    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b01:   lane_rep = {2{w[15:0]}};
            2'b10:   lane_rep = {4{w[7:0]}};
            default: lane_rep = w;
        endcase
    endfunction

`ifdef ALIGN_CHECK_EN
    logic adel_q;

    // Word needs addr[1:0]==0, half needs addr[0]==0; bytes are always legal
    always_comb begin
        misalign = 1'b0;
        if (cpu_req && !cpu_done_q) begin
            case (cpu_size)
                2'b01:   misalign = cpu_addr[0];
                2'b10:   misalign = 1'b0;
                default: misalign = (cpu_addr[1:0] != 2'b00);
            endcase
        end
    end

    // Misalignment flag pulses in the same cycle as the rejecting cpu_done
    always_ff @(posedge clk) begin
        if (reset) adel_q <= 1'b0;
        else       adel_q <= (state_q == S_IDLE) && misalign;
    end

    assign cpu_adel_ades = adel_q;
`else
    assign misalign      = 1'b0;
    assign cpu_adel_ades = 1'b0;
`endif

    // cpu_done_q masks the still-held request during a rejection pulse
    assign cpu_ok = cpu_req && !cpu_done_q && !misalign;

    // Next-state: arbitration in IDLE, latency count in BUSY, done in RESP
    always_comb begin
        state_d     = state_q;
        owner_dma_d = owner_dma_q;
        req_we_d    = req_we_q;
        req_size_d  = req_size_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (misalign) cpu_done_d = 1'b1;
                if (cpu_ok && !(dma_req && starve_q == STARVE_TOP)) begin
                    state_d     = S_BUSY;
                    owner_dma_d = 1'b0;
                    req_we_d    = cpu_we;
                    req_size_d  = cpu_size;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    lat_d       = 2'd0;
                    if (!dma_req)                    starve_d = 3'd0;
                    else if (starve_q != STARVE_TOP) starve_d = starve_q + 3'd1;
                end else if (dma_req) begin
                    state_d     = S_BUSY;
                    owner_dma_d = 1'b1;
                    req_we_d    = dma_we;
                    req_size_d  = 2'b00;
                    req_addr_d  = {dma_addr[31:2], 2'b00};
                    req_wdata_d = dma_wdata;
                    lat_d       = 2'd0;
                    starve_d    = 3'd0;
                end
            end
            S_BUSY: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_RESP;
                    lat_d   = 2'd0;
                    if (owner_dma_q) begin
                        dma_rdata_d = mem_rdata;
                        dma_done_d  = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                        cpu_done_d  = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_dma_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_size_q  <= 2'b00;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            lat_q       <= 2'd0;
            starve_q    <= 3'd0;
            cpu_rdata_q <= 32'h0;
            dma_rdata_q <= 32'h0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dma_q <= owner_dma_d;
            req_we_q    <= req_we_d;
            req_size_q  <= req_size_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
        end
    end

    // DM port decode: strobes only in BUSY, address/data hold between accesses
    assign mem_we    = !reset && (state_q == S_BUSY) && (lat_q == 2'd0) && req_we_q;
    assign mem_be    = (!reset && state_q == S_BUSY) ? byte_en(req_size_q, req_addr_q[1:0]) : 4'b0000;
    assign mem_addr  = {req_addr_q[31:2], 2'b00};
    assign mem_wdata = lane_rep(req_size_q, req_wdata_q);

    assign cpu_stall = cpu_req && !cpu_done_q && !reset;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_done  = dma_done_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_gnt   = !reset && owner_dma_q && (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share
// the clock; a DM model per instance answers reads and applies byte-enabled
// writes. Expected DM bus beats are queued when a request is driven and
// compared when the DUT starts a BUSY phase.
module tb_dm_access_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        gnt;
    } beat_t;

    logic        clk;
    logic        rst       [2];
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [1:0]  cpu_size  [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic        cpu_stall [2];
    logic        cpu_done  [2];
    logic [31:0] cpu_rdata [2];
    logic        dma_req   [2];
    logic        dma_we    [2];
    logic [31:0] dma_addr  [2];
    logic [31:0] dma_wdata [2];
    logic        dma_gnt   [2];
    logic        dma_done  [2];
    logic [31:0] dma_rdata [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        cpu_adel  [2];

    logic [31:0] dm    [2][64];
    logic [31:0] model [2][64];
    logic [3:0]  prev_be [2];
    logic [31:0] last_cpu [2];
    bit          preload_done;
    beat_t       q0[$];
    beat_t       q1[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ncpu;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_access_arbiter #(.MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(3)) u_dut (
            .clk(clk), .reset(rst[g]),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_size(cpu_size[g]),
            .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_stall(cpu_stall[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_gnt(dma_gnt[g]), .dma_done(dma_done[g]),
            .dma_rdata(dma_rdata[g]),
            .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .cpu_adel_ades(cpu_adel[g])
        );
        assign mem_rdata[g] = dm[g][mem_addr[g][7:2]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 8) return 32'hCAFEF00D;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [1:0] a);
        if (s == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        if (s == 2'b10) return 4'b0001 << a;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_rep(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'b01) return {w[15:0], w[15:0]};
        if (s == 2'b10) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        return w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // DM model: preload once, then byte-enabled writes on the clock edge
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 64; i++) dm[d][i] <= init_word(i);
            preload_done <= 1'b1;
        end else begin
            for (int d = 0; d < 2; d++)
                if (mem_we[d])
                    dm[d][mem_addr[d][7:2]] <= merge(dm[d][mem_addr[d][7:2]], mem_wdata[d], mem_be[d]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic mon(input int d);
        beat_t b;
        if (mem_be[d] != 4'h0 && prev_be[d] == 4'h0) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                check_val("unexpected_beat", 32'(mem_be[d]), 32'h0);
            end else begin
                if (d == 0) b = q0.pop_front();
                else        b = q1.pop_front();
                check_val("mem_addr", mem_addr[d], b.addr);
                check_val("mem_be", 32'(mem_be[d]), 32'(b.be));
                check_val("mem_we", 32'(mem_we[d]), 32'(b.we));
                check_val("mem_wdata", mem_wdata[d], b.wdata);
                check_val("dma_gnt", 32'(dma_gnt[d]), 32'(b.gnt));
            end
        end else if (mem_be[d] != 4'h0) begin
            check_val("mem_we_late", 32'(mem_we[d]), 32'h0);
        end
        prev_be[d] = rst[d] ? 4'h0 : mem_be[d];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic chk_zero(input int d);
        check_val("rst_stall", 32'(cpu_stall[d]), 0);
        check_val("rst_cpu_done", 32'(cpu_done[d]), 0);
        check_val("rst_cpu_rdata", cpu_rdata[d], 0);
        check_val("rst_dma_gnt", 32'(dma_gnt[d]), 0);
        check_val("rst_dma_done", 32'(dma_done[d]), 0);
        check_val("rst_dma_rdata", dma_rdata[d], 0);
        check_val("rst_mem_we", 32'(mem_we[d]), 0);
        check_val("rst_mem_be", 32'(mem_be[d]), 0);
        check_val("rst_mem_addr", mem_addr[d], 0);
        check_val("rst_mem_wdata", mem_wdata[d], 0);
        check_val("rst_adel", 32'(cpu_adel[d]), 0);
    endtask

    task automatic wait_done(input int d, input bit is_dma, output int n, output bit stall_ok);
        bit done;
        n = 0;
        stall_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            done = is_dma ? dma_done[d] : cpu_done[d];
            if (!done && !is_dma && !cpu_stall[d]) stall_ok = 1'b0;
        end while (!done && n < 40);
        if (!done) check_val(is_dma ? "dma_timeout" : "cpu_timeout", 32'h0, 32'h1);
    endtask

    task automatic cpu_xact(input int d, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int n, idx, lat;
        bit sok, mis;
        logic [31:0] old, rd;
        beat_t b;
`ifdef ALIGN_CHECK_EN
        mis = (size == 2'b01) ? addr[0] : (size == 2'b10) ? 1'b0 : (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idx = int'(addr[7:2]);
        old = model[d][idx];
        if (!mis) begin
            b = '{addr: {addr[31:2], 2'b00}, be: exp_be(size, addr[1:0]), we: we,
                  wdata: exp_rep(size, wdata), gnt: 1'b0};
            push_beat(d, b);
            if (we) model[d][idx] = merge(old, b.wdata, b.be);
            rd  = (we && lat_of(d) == 1) ? old : model[d][idx];
            lat = lat_of(d) + 1;
        end else begin
            rd  = last_cpu[d];
            lat = 1;
        end
        @(negedge clk);
        cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_size[d] = size;
        cpu_addr[d] = addr; cpu_wdata[d] = wdata;
        wait_done(d, 1'b0, n, sok);
        check_val("cpu_latency", 32'(n), 32'(lat));
        check_val("cpu_rdata", cpu_rdata[d], rd);
        check_val("stall_while_busy", 32'(sok), 32'h1);
        check_val("stall_at_done", 32'(cpu_stall[d]), 32'h0);
        check_val("adel", 32'(cpu_adel[d]), 32'(mis));
        last_cpu[d] = rd;
        @(negedge clk);
        cpu_req[d] = 1'b0;
    endtask

    task automatic dma_xact(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n, idx;
        bit sok;
        logic [31:0] old, rd;
        idx = int'(addr[7:2]);
        old = model[d][idx];
        push_beat(d, '{addr: {addr[31:2], 2'b00}, be: 4'hF, we: we, wdata: wdata, gnt: 1'b1});
        if (we) model[d][idx] = wdata;
        rd = (we && lat_of(d) == 1) ? old : model[d][idx];
        @(negedge clk);
        dma_req[d] = 1'b1; dma_we[d] = we; dma_addr[d] = addr; dma_wdata[d] = wdata;
        wait_done(d, 1'b1, n, sok);
        check_val("dma_latency", 32'(n), 32'(lat_of(d) + 1));
        check_val("dma_rdata", dma_rdata[d], rd);
        check_val("dma_gnt_resp", 32'(dma_gnt[d]), 32'h1);
        @(negedge clk);
        dma_req[d] = 1'b0;
    endtask

    task automatic starve_test(input int d);
        beat_t bc, bd;
        bc = '{addr: 32'h20, be: 4'hF, we: 1'b0, wdata: 32'h0, gnt: 1'b0};
        bd = '{addr: 32'h40, be: 4'hF, we: 1'b0, wdata: 32'h0, gnt: 1'b1};
        push_beat(d, bc); push_beat(d, bc); push_beat(d, bc);
        push_beat(d, bd); push_beat(d, bc);
        ncpu = 0;
        fork
            begin
                int n;
                bit sok;
                @(negedge clk);
                cpu_req[d] = 1'b1; cpu_we[d] = 1'b0; cpu_size[d] = 2'b00;
                cpu_addr[d] = 32'h20; cpu_wdata[d] = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    wait_done(d, 1'b0, n, sok);
                    ncpu++;
                    check_val("starve_cpu_rdata", cpu_rdata[d], model[d][8]);
                end
                @(negedge clk);
                cpu_req[d] = 1'b0;
            end
            begin
                int n;
                bit sok;
                @(negedge clk);
                dma_req[d] = 1'b1; dma_we[d] = 1'b0; dma_addr[d] = 32'h40; dma_wdata[d] = 32'h0;
                wait_done(d, 1'b1, n, sok);
                check_val("dma_after_3_cpu", 32'(ncpu), 32'd3);
                check_val("starve_dma_rdata", dma_rdata[d], model[d][16]);
                @(negedge clk);
                dma_req[d] = 1'b0;
            end
        join
        last_cpu[d] = model[d][8];
    endtask

    task automatic reset_test(input int d);
        bit stray;
        push_beat(d, '{addr: 32'h30, be: 4'hF, we: 1'b1, wdata: 32'h11223344, gnt: 1'b0});
        model[d][12] = 32'h11223344;
        @(negedge clk);
        cpu_req[d] = 1'b1; cpu_we[d] = 1'b1; cpu_size[d] = 2'b00;
        cpu_addr[d] = 32'h30; cpu_wdata[d] = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[d] = 1'b1;
        @(posedge clk);
        #1;
        chk_zero(d);
        @(negedge clk);
        rst[d] = 1'b0;
        cpu_req[d] = 1'b0;
        stray = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (cpu_done[d]) stray = 1'b1;
        end
        check_val("no_done_after_abort", 32'(stray), 32'h0);
        last_cpu[d] = 32'h0;
        cpu_xact(d, 1'b0, 2'b00, 32'h30, 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_size[d] = 2'b00;
            cpu_addr[d] = 32'h0; cpu_wdata[d] = 32'h0; dma_req[d] = 1'b0; dma_we[d] = 1'b0;
            dma_addr[d] = 32'h0; dma_wdata[d] = 32'h0; prev_be[d] = 4'h0; last_cpu[d] = 32'h0;
            for (int i = 0; i < 64; i++) model[d][i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            cpu_xact(d, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
            cpu_xact(d, 1'b1, 2'b10, 32'h13, 32'h000000A5);
            cpu_xact(d, 1'b1, 2'b01, 32'h12, 32'h00001234);
            cpu_xact(d, 1'b0, 2'b00, 32'h10, 32'h0);
            cpu_xact(d, 1'b0, 2'b00, 32'h20, 32'h0);
            cpu_xact(d, 1'b0, 2'b10, 32'h21, 32'h0);
            cpu_xact(d, 1'b1, 2'b01, 32'h06, 32'hFFFF9876);
            cpu_xact(d, 1'b1, 2'b11, 32'h24, 32'h0BADF00D);
            dma_xact(d, 1'b1, 32'h43, 32'h55667788);
            dma_xact(d, 1'b0, 32'h40, 32'h0);
            cpu_xact(d, 1'b0, 2'b00, 32'h40, 32'h0);
            starve_test(d);
            cpu_xact(d, 1'b0, 2'b00, 32'h22, 32'h0);
            cpu_xact(d, 1'b0, 2'b01, 32'h05, 32'h0);
        end
        reset_test(1);

        repeat (3) @(posedge clk);
        check_val("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Arbitrates the single data-memory (DM) port between the pipeline M stage (CPU) and a DMA/loader requester.
- Sequences each access as a multi-cycle transaction.
- Builds byte enables and lane-replicated write data from address and access size.
- Stalls the pipeline until the CPU access completes.
- Sits between the M-stage datapath and DM; load sign/zero extension remains in the W stage.

Parameters:
MEM_LAT, 1, DM cycles per access (legal 1..4).
STARVE_MAX, 3, consecutive CPU grants with dma_req pending before DMA is forced first (legal 1..7).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
cpu_req  input  1  CPU access request; held with its fields until cpu_done
cpu_we  input  1  1 = store, 0 = load
cpu_size  input  2  00 word, 01 half, 10 byte (11 treated as word)
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data, right-aligned
cpu_stall  output  1  freeze F/D/E/M
cpu_done  output  1  one-cycle completion pulse
cpu_rdata  output  32  raw DM word of last CPU load
dma_req  input  1  DMA word request; held with its fields until dma_done
dma_we  input  1  DMA write
dma_addr  input  32  word address (bits 1:0 ignored)
dma_wdata  input  32  DMA write word
dma_gnt  output  1  DMA owns the port
dma_done  output  1  one-cycle completion pulse
dma_rdata  output  32  raw DM word of last DMA read
mem_we  output  1  DM write strobe
mem_be  output  4  DM byte enables
mem_addr  output  32  DM address, bits 1:0 forced 0
mem_wdata  output  32  DM write data
mem_rdata  input  32  DM read data, valid in the last BUSY cycle
cpu_adel_ades  output  1  misalignment pulse (ALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset, and any cycle with reset=1: state IDLE, owner CPU, latency counter 0, starvation counter 0, cpu_rdata/dma_rdata 0, all outputs 0.
- Reset mid-transaction aborts it: no done pulse; mem_we low from the next edge.
- FSM states: IDLE, BUSY, RESP. Arbitration happens only in IDLE.
- IDLE: pick a grant and go to BUSY, or stay if no request.
  - Only cpu_req -> CPU.
  - Only dma_req -> DMA.
  - Both -> CPU, unless the starvation counter equals STARVE_MAX, then DMA.
  - On grant, latch owner, we, size, address and write data into request registers.
- BUSY: lasts exactly MEM_LAT cycles, counted by the latency counter.
  - mem_* are driven from the request registers.
  - mem_we is high only in the first BUSY cycle and only for writes.
  - On the last BUSY cycle, mem_rdata is captured into the owner's rdata register. The capture happens on writes too.
  - Next state is RESP.
- RESP: one cycle. The owner's done pulses and its rdata is valid. Next state is IDLE.
- Latency: request seen in IDLE at cycle t -> BUSY t+1..t+MEM_LAT -> done at t+MEM_LAT+1. Minimum 3 cycles.
- cpu_stall = cpu_req & ~cpu_done. It is low during the done cycle so the pipeline advances on that edge.
- dma_gnt is high during BUSY and RESP when the owner is DMA.
- Starvation counter:
  - +1 on each CPU grant while dma_req=1, saturating at STARVE_MAX.
  - Cleared on a DMA grant.
  - Cleared on a CPU grant while dma_req=0.
- Byte enables:
  - CPU word -> 1111.
  - CPU half -> 0011 if addr[1]=0, else 1100.
  - CPU byte -> one-hot at bit addr[1:0].
  - DMA -> 1111.
- Write data replication:
  - byte -> {4{wdata[7:0]}}
  - half -> {2{wdata[15:0]}}
  - word -> unchanged
- Outside BUSY: mem_we=0, mem_be=0, mem_addr and mem_wdata hold their last value.
- Requests arriving during BUSY/RESP wait for IDLE; they are not lost because requesters hold req.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined: in IDLE, a CPU request with word addr[1:0]!=0 or half addr[0]!=0 is not granted to DM.
  - No BUSY cycles; no mem_we.
  - cpu_adel_ades and cpu_done pulse together in the next cycle; cpu_rdata unchanged.
  - A simultaneous dma_req is granted in the same IDLE cycle.
- Undefined: no check. Low address bits only select enables; cpu_adel_ades is tied 0.

Test Plan:
- MEM_LAT=1, CPU sw addr 0x10 data 0xDEADBEEF at cycle 2 -> mem_we=1, be=1111, addr 0x10 at cycle 3; cpu_done at 4; cpu_stall high cycles 2-3.
- CPU sb addr 0x13 data 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5; sh addr 0x12 data 0x1234 -> be=1100, wdata 0x12341234.
- MEM_LAT=3, CPU lw 0x20 with DM returning 0xCAFEF00D -> BUSY 3 cycles, mem_we never high, cpu_done 4 cycles after request, cpu_rdata=0xCAFEF00D.
- STARVE_MAX=3, cpu_req and dma_req both held continuously -> grant order CPU,CPU,CPU,DMA,CPU,...; dma_done only after the 3rd CPU completion.
- Reset asserted in the 2nd BUSY cycle of a CPU store (MEM_LAT=3) -> no cpu_done; all outputs 0 next cycle; a new CPU request afterwards is granted normally.
- ALIGN_CHECK_EN defined, CPU lw 0x22 -> cpu_adel_ades=cpu_done=1 next cycle, mem_we/be stay 0; with the macro undefined the same access reads with be=1111.
